// File: rtl/lbp_host_mem.sv
// lbp_host_mem: host-side memory responder for the LBP engine.
// Loads a gray image over a ready/valid stream and serves the engine's
// combinational pixel reads. It captures the engine's LBP result writes into
// a result RAM, then streams the result image out in raster order once the
// engine signals completion.
module lbp_host_mem #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_valid,
  input  logic [DATA_W-1:0] img_data,
  output logic              img_ready,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_valid,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  input  logic              res_ready,
  output logic              done,
  output logic              proto_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DUMP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_img_ready;
  logic              r_gray_ready;
  logic              r_res_valid;
  logic              r_res_last;
  logic              r_done;
  logic              r_proto_err;

  logic [DATA_W-1:0] r_gray_mem [DEPTH];
  logic [DATA_W-1:0] r_res_mem  [DEPTH];

  logic              w_img_acc;
  logic              w_lbp_wr;
  logic              w_wr_last;
  logic [ADDR_W-1:0] w_wr_next;
  logic [ADDR_W-1:0] w_rd_next;

  // A pixel is taken only while the load port is open; reset blocks writes
  // so a reset cycle never disturbs memory contents.
  assign w_img_acc = img_valid & r_img_ready & ~reset;
  // Engine writes land only while serving; writes after finish are dropped.
  assign w_lbp_wr  = lbp_valid & (r_state == S_SERVE) & ~reset;
  assign w_wr_last = &r_wr_ptr;
  assign w_wr_next = r_wr_ptr + ADDR_W'(1);
  assign w_rd_next = r_rd_ptr + ADDR_W'(1);

  assign img_ready  = r_img_ready;
  assign gray_ready = r_gray_ready;
  assign res_valid  = r_res_valid;
  assign res_last   = r_res_last;
  assign done       = r_done;
  assign proto_err  = r_proto_err;

  // Both reads are asynchronous; res_data is stable under backpressure
  // because rd_ptr only advances on a completed handshake.
  assign gray_data = r_gray_mem[gray_addr];
  assign res_data  = r_res_mem[r_rd_ptr];

  // Gray image capture during LOAD
  always_ff @(posedge clk) begin
    if (w_img_acc) r_gray_mem[r_wr_ptr] <= img_data;
  end

  // Result RAM: cleared pixel-by-pixel during LOAD so border pixels read 0,
  // then written by the engine during SERVE (last write wins)
  always_ff @(posedge clk) begin
    if (w_img_acc) begin
      r_res_mem[r_wr_ptr] <= '0;
    end else if (w_lbp_wr) begin
      r_res_mem[lbp_addr] <= lbp_data;
    end
  end

  // Control FSM: state, pointers and registered state-decoded outputs.
  // res_last is precomputed from the pointer value it will hold next.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_img_ready  <= 1'b1;
      r_gray_ready <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_last   <= 1'b0;
      r_done       <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          // The engine must stay idle until the image is resident.
          if (gray_req | lbp_valid) r_proto_err <= 1'b1;
          if (img_valid) begin
            r_wr_ptr <= w_wr_next;
            if (w_wr_last) begin
              r_state      <= S_SERVE;
              r_img_ready  <= 1'b0;
              r_gray_ready <= 1'b1;
            end
          end
        end
        S_SERVE: begin
          if (finish) begin
            r_state     <= S_DUMP;
            r_res_valid <= 1'b1;
            r_res_last  <= &r_rd_ptr;
          end
        end
        S_DUMP: begin
          if (res_ready) begin
            if (r_res_last) begin
              r_state     <= S_DONE;
              r_rd_ptr    <= '0;
              r_res_valid <= 1'b0;
              r_res_last  <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_rd_ptr   <= w_rd_next;
              r_res_last <= &w_rd_next;
            end
          end
        end
        S_DONE: begin
          // The pixel offered here only reopens the load port; it is not taken.
          if (img_valid) begin
            r_state      <= S_LOAD;
            r_done       <= 1'b0;
            r_gray_ready <= 1'b0;
            r_img_ready  <= 1'b1;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_host_mem.sv
// Testbench for lbp_host_mem: full-size instance for load/serve/dump/restart
// and a small-depth instance for the mid-dump reset sequence.
module tb_lbp_host_mem;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;
  localparam int SAW = 3;
  localparam int SDEPTH = 1 << SAW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, img_valid, img_ready, gray_req, gray_ready;
  logic [DW-1:0] img_data, gray_data, lbp_data, res_data;
  logic [AW-1:0] gray_addr, lbp_addr;
  logic          lbp_valid, finish, res_valid, res_last, res_ready, done, proto_err;

  logic           s_reset, s_img_valid, s_img_ready, s_gray_req, s_gray_ready;
  logic [DW-1:0]  s_img_data, s_gray_data, s_lbp_data, s_res_data;
  logic [SAW-1:0] s_gray_addr, s_lbp_addr;
  logic           s_lbp_valid, s_finish, s_res_valid, s_res_last, s_res_ready, s_done, s_proto_err;

  lbp_host_mem #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk(clk), .reset(reset), .img_valid(img_valid), .img_data(img_data),
    .img_ready(img_ready), .gray_addr(gray_addr), .gray_req(gray_req),
    .gray_ready(gray_ready), .gray_data(gray_data), .lbp_addr(lbp_addr),
    .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .res_ready(res_ready), .done(done), .proto_err(proto_err)
  );

  lbp_host_mem #(.ADDR_W(SAW), .DATA_W(DW)) u_small (
    .clk(clk), .reset(s_reset), .img_valid(s_img_valid), .img_data(s_img_data),
    .img_ready(s_img_ready), .gray_addr(s_gray_addr), .gray_req(s_gray_req),
    .gray_ready(s_gray_ready), .gray_data(s_gray_data), .lbp_addr(s_lbp_addr),
    .lbp_valid(s_lbp_valid), .lbp_data(s_lbp_data), .finish(s_finish),
    .res_valid(s_res_valid), .res_data(s_res_data), .res_last(s_res_last),
    .res_ready(s_res_ready), .done(s_done), .proto_err(s_proto_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: image and result contents as the host should see them.
  logic [DW-1:0] gray_m [DEPTH];
  logic [DW-1:0] res_m  [DEPTH];

  typedef struct {
    logic          wv;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] exp_gray;
    logic [DW-1:0] exp_res0;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream a full image; pixel value from pattern (0: addr[7:0], 1: random).
  task automatic load_image(input int with_gaps, input int random_px, input string tag);
    int acc = 0;
    int cyc = 0;
    int ready_lo = 0;
    while (acc < DEPTH && cyc < 2 * DEPTH) begin
      img_valid = (with_gaps != 0) ? (cyc % 7 != 6) : 1'b1;
      img_data  = (random_px != 0) ? 8'($urandom) : acc[7:0];
      gray_req  = (with_gaps != 0) && (cyc == 3);
      #1;
      if (img_ready !== 1'b1) ready_lo++;
      if (acc == DEPTH - 1 && img_valid) check({tag, "_gray_ready_before_last"}, 32'(gray_ready), 32'd0);
      if (img_valid && img_ready === 1'b1) begin
        gray_m[acc] = img_data;
        res_m[acc]  = '0;
        acc++;
      end
      step();
      cyc++;
      if (with_gaps != 0 && cyc == 4) check("proto_err_set_in_load", 32'(proto_err), 32'd1);
    end
    img_valid = 1'b0;
    gray_req  = 1'b0;
    check({tag, "_accepted"}, 32'(acc), 32'(DEPTH));
    check({tag, "_img_ready_low_cycles"}, 32'(ready_lo), 32'd0);
    check({tag, "_gray_ready_after_load"}, 32'(gray_ready), 32'd1);
    check({tag, "_img_ready_after_load"}, 32'(img_ready), 32'd0);
  endtask

  task automatic gray_sweep(input string tag);
    int errs = 0;
    for (int a = 0; a < DEPTH; a++) begin
      gray_addr = a[AW-1:0];
      #1;
      if (gray_data !== gray_m[a]) errs++;
    end
    check({tag, "_gray_sweep_mismatches"}, 32'(errs), 32'd0);
    step();
  endtask

  // Drain the result image; alt_ready toggles res_ready every cycle.
  task automatic dump_image(input int alt_ready, input string tag,
                            output logic [DW-1:0] px0, output logic [DW-1:0] px81,
                            output logic [DW-1:0] px3efe);
    int hs = 0;
    int cyc = 0;
    int e_data = 0, e_stable = 0, e_last = 0, e_valid = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] prev = '0;
    px0 = 'x; px81 = 'x; px3efe = 'x;
    while (hs < DEPTH && cyc < 2 * DEPTH + 16) begin
      res_ready = (alt_ready != 0) ? (cyc % 2 == 0) : 1'b1;
      lbp_valid = 1'b1;
      lbp_addr  = AW'($urandom);
      lbp_data  = 8'($urandom);
      #1;
      if (res_valid !== 1'b1) e_valid++;
      if (res_data !== res_m[hs]) e_data++;
      if (stalled && res_data !== prev) e_stable++;
      if (res_last !== (hs == DEPTH - 1)) e_last++;
      if (res_valid === 1'b1 && res_ready) begin
        if (hs == 0) px0 = res_data;
        if (hs == 'h81) px81 = res_data;
        if (hs == 'h3EFE) px3efe = res_data;
        if (hs == DEPTH - 1) check({tag, "_done_low_at_last"}, 32'(done), 32'd0);
        hs++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = res_data;
      end
      step();
      cyc++;
    end
    lbp_valid = 1'b0;
    res_ready = 1'b0;
    check({tag, "_handshakes"}, 32'(hs), 32'(DEPTH));
    check({tag, "_data_mismatches"}, 32'(e_data), 32'd0);
    check({tag, "_stall_instability"}, 32'(e_stable), 32'd0);
    check({tag, "_res_last_errors"}, 32'(e_last), 32'd0);
    check({tag, "_res_valid_drops"}, 32'(e_valid), 32'd0);
    check({tag, "_done_after_drain"}, 32'(done), 32'd1);
    check({tag, "_res_valid_after_drain"}, 32'(res_valid), 32'd0);
    check({tag, "_gray_ready_in_done"}, 32'(gray_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] p0, p81, p3efe;
    int e;

    tbl[0] = '{1'b1, 14'h0000, 8'h37, 14'h0081, 8'h81, 8'h37};
    tbl[1] = '{1'b0, 14'h0000, 8'hFF, 14'h3FFF, 8'hFF, 8'h37};
    tbl[2] = '{1'b1, 14'h0001, 8'h99, 14'h1234, 8'h34, 8'h37};
    tbl[3] = '{1'b1, 14'h0000, 8'hA5, 14'h0000, 8'h00, 8'hA5};
    tbl[4] = '{1'b1, 14'h3FFF, 8'h77, 14'h00FF, 8'hFF, 8'hA5};
    tbl[5] = '{1'b1, 14'h0000, 8'h00, 14'h2080, 8'h80, 8'h00};

    reset = 1'b1; img_valid = 0; img_data = 0; gray_addr = 0; gray_req = 0;
    lbp_addr = 0; lbp_valid = 0; lbp_data = 0; finish = 0; res_ready = 0;
    s_reset = 1'b1; s_img_valid = 0; s_img_data = 0; s_gray_addr = 0; s_gray_req = 0;
    s_lbp_addr = 0; s_lbp_valid = 0; s_lbp_data = 0; s_finish = 0; s_res_ready = 0;
    step(); step();
    reset = 1'b0;

    check("rst_img_ready", 32'(img_ready), 32'd1);
    check("rst_gray_ready", 32'(gray_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_last", 32'(res_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);

    // Pass 1: address-pattern image with valid gaps, gray_req poked in LOAD.
    load_image(1, 0, "load1");
    check("proto_err_sticky", 32'(proto_err), 32'd1);
    gray_addr = 14'h0081;
    #1;
    check("gray_0081", 32'(gray_data), 32'h81);
    gray_sweep("serve1");

    for (int i = 0; i < 6; i++) begin
      lbp_valid = tbl[i].wv;
      lbp_addr  = tbl[i].waddr;
      lbp_data  = tbl[i].wdata;
      gray_addr = tbl[i].gaddr;
      #1;
      check($sformatf("tbl%0d_gray", i), 32'(gray_data), 32'(tbl[i].exp_gray));
      if (tbl[i].wv) res_m[tbl[i].waddr] = tbl[i].wdata;
      step();
      check($sformatf("tbl%0d_res0", i), 32'(res_data), 32'(tbl[i].exp_res0));
    end

    e = 0;
    for (int i = 0; i < 300; i++) begin
      lbp_valid = 1'($urandom);
      lbp_addr  = AW'($urandom_range(16'h0100, 16'h3E00));
      lbp_data  = 8'($urandom);
      gray_addr = AW'($urandom);
      #1;
      if (gray_data !== gray_m[gray_addr]) e++;
      if (res_valid !== 1'b0 || done !== 1'b0) e++;
      if (lbp_valid) res_m[lbp_addr] = lbp_data;
      step();
    end
    check("serve1_random_mismatches", 32'(e), 32'd0);

    lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'h5A; step();
    lbp_data = 8'hC3; step();
    res_m[14'h0081] = 8'hC3;

    // finish and a write in the same cycle: write still lands
    lbp_addr = 14'h3EFE; lbp_data = 8'h11; finish = 1'b1;
    #1;
    check("res_valid_before_dump", 32'(res_valid), 32'd0);
    res_m[14'h3EFE] = 8'h11;
    step();
    finish = 1'b0; lbp_valid = 1'b0;
    check("dump_entered", 32'(res_valid), 32'd1);

    dump_image(1, "dump1", p0, p81, p3efe);
    check("px_0000_border", 32'(p0), 32'h00);
    check("px_0081_last_write", 32'(p81), 32'hC3);
    check("px_3efe_collision", 32'(p3efe), 32'h11);

    // Restart from DONE: offered pixel reopens LOAD but is not taken.
    img_valid = 1'b1; img_data = 8'hAB;
    #1;
    check("img_ready_in_done", 32'(img_ready), 32'd0);
    step();
    check("load_after_done", 32'(img_ready), 32'd1);
    check("done_low_after_restart", 32'(done), 32'd0);
    check("gray_ready_low_after_restart", 32'(gray_ready), 32'd0);

    load_image(0, 1, "load2");
    gray_sweep("serve2");
    for (int i = 0; i < 200; i++) begin
      lbp_valid = 1'($urandom);
      lbp_addr  = AW'($urandom);
      lbp_data  = 8'($urandom);
      if (lbp_valid) res_m[lbp_addr] = lbp_data;
      step();
    end
    lbp_valid = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    dump_image(0, "dump2", p0, p81, p3efe);
    check("proto_err_still_sticky", 32'(proto_err), 32'd1);

    // Small instance: reset in the middle of a dump.
    s_reset = 1'b0;
    for (int i = 0; i < SDEPTH; i++) begin
      s_img_valid = 1'b1; s_img_data = 8'(i * 3); s_lbp_valid = (i == 0);
      step();
      if (i == 0) check("s_proto_err_lbp_in_load", 32'(s_proto_err), 32'd1);
    end
    s_img_valid = 1'b0; s_lbp_valid = 1'b0;
    check("s_gray_ready_loaded", 32'(s_gray_ready), 32'd1);
    s_finish = 1'b1; step(); s_finish = 1'b0;
    s_res_ready = 1'b1; step(); step(); step(); s_res_ready = 1'b0;
    check("s_in_dump", 32'(s_res_valid), 32'd1);
    s_reset = 1'b1; step(); s_reset = 1'b0;
    check("s_rst_img_ready", 32'(s_img_ready), 32'd1);
    check("s_rst_res_valid", 32'(s_res_valid), 32'd0);
    check("s_rst_proto_err", 32'(s_proto_err), 32'd0);
    check("s_rst_gray_ready", 32'(s_gray_ready), 32'd0);
    check("s_rst_done", 32'(s_done), 32'd0);
    for (int i = 0; i < SDEPTH; i++) begin
      s_img_valid = 1'b1; s_img_data = 8'hF0;
      step();
      if (i == SDEPTH - 2) check("s_reload_not_early", 32'(s_gray_ready), 32'd0);
    end
    s_img_valid = 1'b0;
    check("s_reload_complete", 32'(s_gray_ready), 32'd1);
    s_finish = 1'b1; step(); s_finish = 1'b0;
    e = 0;
    s_res_ready = 1'b1;
    for (int i = 0; i < SDEPTH; i++) begin
      #1;
      if (s_res_last !== (i == SDEPTH - 1) || s_res_data !== 8'h00 || s_res_valid !== 1'b1) e++;
      step();
    end
    s_res_ready = 1'b0;
    check("s_redump_errors", 32'(e), 32'd0);
    check("s_done_after_redump", 32'(s_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lbp_host_mem.md
# lbp_host_mem

Host-side memory responder for the LBP engine's gray-read and LBP-write ports. It holds a 128×128 gray image loaded over a streaming input and serves the engine's pixel reads. It captures the engine's LBP result writes into a result RAM. After the engine raises `finish`, it streams the full result image out in raster order. It sits between the system's image source/sink and the LBP engine, and replaces the behavioural memories used around the engine.

## Interface
- `ADDR_W`, default 14: address width; image depth is `1<<ADDR_W` (16384 = 128×128).
- `DATA_W`, default 8: pixel width for both gray and LBP data.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `img_valid` in 1: an image pixel is offered on `img_data`.
- `img_data` in `DATA_W`: gray pixel, raster order, address 0 first.
- `img_ready` out 1: high only in LOAD; a pixel is accepted when `img_valid & img_ready`.
- `gray_addr` in `ADDR_W`: read address from the engine.
- `gray_req` in 1: engine read strobe; it is sampled by the engine in the same cycle.
- `gray_ready` out 1: high in SERVE, DUMP and DONE (the image is resident).
- `gray_data` out `DATA_W`: combinational read, `gray_mem[gray_addr]`.
- `lbp_addr` in `ADDR_W`: write address from the engine.
- `lbp_valid` in 1: write strobe.
- `lbp_data` in `DATA_W`: LBP value to store.
- `finish` in 1: engine completion level.
- `res_valid` out 1: result pixel available; high throughout DUMP.
- `res_data` out `DATA_W`: `res_mem[rd_ptr]`.
- `res_last` out 1: `res_valid & (rd_ptr == DEPTH-1)`.
- `res_ready` in 1: downstream accepts the result pixel.
- `done` out 1: high in DONE.
- `proto_err` out 1: sticky error flag; cleared only by reset.

## Operation
State machine: LOAD → SERVE → DUMP → DONE → LOAD.

LOAD (state after reset):
- `img_ready`=1.
- Each accepted pixel writes `gray_mem[wr_ptr]`, writes `res_mem[wr_ptr]`=0 (clears border pixels), and increments `wr_ptr`.
- Accepting the pixel at `wr_ptr == DEPTH-1` moves to SERVE and wraps `wr_ptr` to 0.

SERVE:
- `gray_ready`=1.
- Every cycle with `lbp_valid`=1 writes `res_mem[lbp_addr] <= lbp_data`. The last write wins on a repeated address.
- `finish`=1 moves to DUMP. A `lbp_valid` in that same cycle is still written.

DUMP:
- `res_valid`=1.
- On `res_valid & res_ready`, `rd_ptr` increments.
- The handshake with `res_last`=1 moves to DONE and resets `rd_ptr` to 0.
- `lbp_valid` is ignored here and not flagged; the engine may keep writing after `finish`.
- `gray_data` continues to be served.

DONE:
- `done`=1 and `gray_ready`=1.
- `img_valid`=1 moves to LOAD. The pixel is not accepted in that cycle (`img_ready`=0 in DONE).

`proto_err` is set when `gray_req` or `lbp_valid` is 1 in LOAD.

Memory and data rules:
- Both memories are `DEPTH × DATA_W` arrays.
- The `gray_mem` read is asynchronous; `gray_data` is valid in the same cycle `gray_addr` changes.
- `res_data` is also an asynchronous read of `res_mem[rd_ptr]`. It is held stable while `res_valid & ~res_ready`.
- Addresses are unsigned, `ADDR_W` bits; there is no range check (the full range is valid).

## Timing
Reset values:
- State = LOAD; `wr_ptr` = `rd_ptr` = 0.
- `img_ready`=1, `gray_ready`=0, `res_valid`=0, `res_last`=0, `done`=0, `proto_err`=0.
- `gray_data` = `gray_mem[gray_addr]`; memory contents are not reset.

Latencies:
- Image load takes exactly 16384 handshake cycles. `gray_ready` rises in the cycle after the last accepted pixel.
- Read latency is 0 cycles: `gray_data` follows `gray_addr` combinationally. The engine drives the address one cycle and samples with `gray_req` the next.
- A write issued in cycle N with `lbp_valid` is readable via `res_data` from cycle N+1.
- DUMP starts the cycle after `finish` is sampled. With `res_ready` held at 1, it drains 16384 pixels in 16384 cycles and `done` rises the next cycle.

Other timing rules:
- `finish` is level-sensitive and is only acted on in SERVE. A `finish` already high on entry to SERVE causes an immediate transition one cycle later.
- Reset asserted mid-operation (any state) returns to LOAD on the next edge and discards the pointers. The image must be reloaded.

## Test plan
- **Load and ready:** stream 16384 pixels, value = `addr[7:0]`, with `img_valid` gaps every 7th cycle → `img_ready`=1 throughout; `gray_ready` rises one cycle after the 16384th acceptance; `gray_data` at `gray_addr`=0x0081 reads 0x81.
- **Read/write service:**
  - In SERVE, drive `gray_addr`=0x0000..0x3FFF → `gray_data` = `addr[7:0]` in the same cycle.
  - Write `lbp_addr`=0x0081 with 0x5A, then the same address with 0xC3 → `res_mem[0x81]` = 0xC3.
- **Finish + write collision:** `lbp_valid`=1 (`lbp_addr`=0x3EFE, `lbp_data`=0x11) in the same cycle as `finish`=1 → stored; DUMP entered next cycle; pixel 0x3EFE emerges as 0x11; border pixel 0x0000 emerges as 0x00.
- **Dump backpressure:** toggle `res_ready` 1/0 on alternating cycles → `res_data` stable while stalled; exactly 16384 handshakes; `res_last` only on the last one; `done` one cycle later.
- **Protocol error and reset:**
  - `gray_req`=1 during LOAD → `proto_err`=1 and stays 1.
  - Assert `reset` mid-DUMP → next cycle state is LOAD, `res_valid`=0, `proto_err`=0, `img_ready`=1.
- **Restart:** in DONE, raise `img_valid` → one cycle later state is LOAD; a second image of 16384 pixels loads, and a full SERVE→DUMP pass returns the new results.
